fetch_sequencer: RTL and testbench

Instruction-fetch controller that sits between the CPU's word-addressed instruction memory and the decode stage. It owns the fetch program counter, drives the memory address, and buffers fetched instructions with their PCs in a small FIFO. Decode consumes entries through a valid/ready handshake. It also handles control-flow redirects, such as a taken branch, jump or jr, and faults on illegal fetch addresses.

---
 rtl/fetch_sequencer.sv | 123 ++++++++++++
 tb/tb_fetch_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, reads word-addressed instruction
// memory and buffers {pc, instr} pairs in a small FIFO drained by decode.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic [31:0]                   imem_addr,
    input  logic [31:0]                   imem_data,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_target,
    output logic                          instr_valid,
    output logic [31:0]                   instr_out,
    output logic [31:0]                   instr_pc,
    input  logic                          instr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic                          fault,
    output logic [31:0]                   fault_pc
);

    localparam int             PW      = $clog2(FIFO_DEPTH);
    localparam logic [31:0]    LAST_PC = 32'(MEM_WORDS * 4 - 4);
    localparam logic [PW:0]    DEPTH   = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0]    OCC_ONE = (PW + 1)'(1);
    localparam logic [PW-1:0]  PTR_ONE = PW'(1);

    logic [31:0]   fetchPc_q, fetchPc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   occ_q, occ_d;
    logic          fault_q, fault_d;
    logic [31:0]   faultPc_q, faultPc_d;

    logic [31:0]   fifoInstr_q [FIFO_DEPTH];
    logic [31:0]   fifoPc_q    [FIFO_DEPTH];

    logic pop;
    logic push;
    logic pcLegal;
    logic doRedirect;
    logic targetBad;

    assign pcLegal    = (fetchPc_q <= LAST_PC) && (fetchPc_q[1:0] == 2'b00);
    assign pop        = (occ_q != '0) && instr_ready;
    assign push       = !fault_q && !redirect_valid && ((occ_q < DEPTH) || pop) && pcLegal;
    assign doRedirect = redirect_valid && !fault_q;
    assign targetBad  = (redirect_target[1:0] != 2'b00) || (redirect_target > LAST_PC);

    // A live redirect flushes the buffer and wins over any push or pop in the same cycle.
    always_comb begin
        fetchPc_d = fetchPc_q;
        head_d    = head_q;
        tail_d    = tail_q;
        occ_d     = occ_q;
        fault_d   = fault_q;
        faultPc_d = faultPc_q;
        if (doRedirect) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
            if (targetBad) begin
                fault_d   = 1'b1;
                faultPc_d = redirect_target;
            end else begin
                fetchPc_d = redirect_target;
            end
        end else begin
            if (!fault_q && !pcLegal) begin
                fault_d   = 1'b1;
                faultPc_d = fetchPc_q;
            end
            if (push) begin
                tail_d    = tail_q + PTR_ONE;
                fetchPc_d = fetchPc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + PTR_ONE;
            end
            if (push && !pop) begin
                occ_d = occ_q + OCC_ONE;
            end else if (pop && !push) begin
                occ_d = occ_q - OCC_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetchPc_q <= RESET_PC;
            head_q    <= '0;
            tail_q    <= '0;
            occ_q     <= '0;
            fault_q   <= 1'b0;
            faultPc_q <= '0;
        end else begin
            fetchPc_q <= fetchPc_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            occ_q     <= occ_d;
            fault_q   <= fault_d;
            faultPc_q <= faultPc_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoInstr_q[tail_q] <= imem_data;
            fifoPc_q[tail_q]    <= fetchPc_q;
        end
    end

    assign imem_addr   = fetchPc_q;
    assign instr_valid = (occ_q != '0);
    assign instr_out   = instr_valid ? fifoInstr_q[head_q] : 32'h0;
    assign instr_pc    = instr_valid ? fifoPc_q[head_q] : 32'h0;
    assign occupancy   = occ_q;
    assign fault       = fault_q;
    assign fault_pc    = faultPc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// redirect/ready traffic compared against a queue-based fetch model.
module tb_fetch_sequencer;

   localparam int          MEM_WORDS  = 1024;
   localparam int          FIFO_DEPTH = 2;
   localparam logic [31:0] LAST_PC    = 32'(MEM_WORDS * 4 - 4);

   logic        clock;
   logic        reset_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic [1:0]  occupancy;
   logic        fault;
   logic [31:0] fault_pc;

   logic [31:0] mem [MEM_WORDS];

   logic [63:0] expQ [$];
   logic [31:0] mPc;
   logic        mFault;
   logic [31:0] mFaultPc;

   int testCount = 0;
   int failCount = 0;

   fetch_sequencer #(
      .RESET_PC   (32'h0000_0000),
      .MEM_WORDS  (MEM_WORDS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk             (clock),
      .reset_n         (reset_n),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .instr_valid     (instr_valid),
      .instr_out       (instr_out),
      .instr_pc        (instr_pc),
      .instr_ready     (instr_ready),
      .occupancy       (occupancy),
      .fault           (fault),
      .fault_pc        (fault_pc)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Instruction memory behaves like a combinational ROM
   assign imem_data = (imem_addr <= LAST_PC) ? mem[imem_addr[11:2]] : 32'hDEAD_BEEF;

   // One comparison: count it and report any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Compare every visible output against the model
   task automatic compareAll(input string tag);
      logic [63:0] head;
      head = (expQ.size() > 0) ? expQ[0] : 64'h0;
      checkOutput({tag, ".valid"}, 32'(instr_valid), 32'(expQ.size() > 0));
      checkOutput({tag, ".pc"}, instr_pc, head[63:32]);
      checkOutput({tag, ".instr"}, instr_out, head[31:0]);
      checkOutput({tag, ".occ"}, 32'(occupancy), 32'(expQ.size()));
      checkOutput({tag, ".addr"}, imem_addr, mPc);
      checkOutput({tag, ".fault"}, 32'(fault), 32'(mFault));
      checkOutput({tag, ".faultpc"}, fault_pc, mFaultPc);
   endtask

   // Reference model: restart fetch from the reset PC with an empty buffer
   task automatic modelReset();
      expQ.delete();
      mPc      = 32'h0;
      mFault   = 1'b0;
      mFaultPc = 32'h0;
   endtask

   // Reference model: effect of one rising edge given the current inputs
   task automatic modelStep();
      bit popNow;
      popNow = (expQ.size() > 0) && instr_ready;
      if (redirect_valid && !mFault) begin
         expQ.delete();
         if (redirect_target[1:0] != 2'b00 || redirect_target > LAST_PC) begin
            mFault   = 1'b1;
            mFaultPc = redirect_target;
         end else begin
            mPc = redirect_target;
         end
      end else begin
         if (popNow) void'(expQ.pop_front());
         if (!mFault) begin
            if (mPc > LAST_PC) begin
               mFault   = 1'b1;
               mFaultPc = mPc;
            end else if (expQ.size() < FIFO_DEPTH) begin
               expQ.push_back({mPc, mem[mPc / 4]});
               mPc = mPc + 4;
            end
         end
      end
   endtask

   // Drive one cycle of inputs from a falling edge, step model, check at next falling edge
   task automatic applyStimulus(input logic rv, input logic [31:0] tgt, input logic rdy, input string tag);
      redirect_valid  = rv;
      redirect_target = tgt;
      instr_ready     = rdy;
      @(posedge clock);
      modelStep();
      @(negedge clock);
      compareAll(tag);
   endtask

   task automatic applyReset();
      reset_n        = 1'b0;
      redirect_valid = 1'b0;
      modelReset();
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      compareAll("reset");
   endtask

   function automatic logic [31:0] randTarget();
      int sel;
      sel = $urandom_range(0, 19);
      if (sel < 14) return 32'($urandom_range(0, 63) * 4);
      else if (sel < 18) return 32'h0000_0FE0 + 32'($urandom_range(0, 7) * 4);
      else if (sel == 18) return 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(1, 3));
      else return 32'h0000_1000 + 32'($urandom_range(0, 15) * 4);
   endfunction

   // Directed scenarios first, then randomized traffic
   initial begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h1000_0000 + 32'(i);
      reset_n         = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      instr_ready     = 1'b1;
      modelReset();
      @(negedge clock);
      #1;
      compareAll("inreset");
      applyReset();

      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1, "stream");

      applyReset();
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b0, "stall");
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, "resume");

      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, "fill");
      applyStimulus(1'b1, 32'h40, 1'b1, "redir40");
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, "after40");

      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, "fill42");
      applyStimulus(1'b1, 32'h42, 1'b0, "redir42");
      applyStimulus(1'b1, 32'h80, 1'b1, "ignored");
      applyStimulus(1'b0, 32'h0, 1'b1, "frozen");

      applyReset();
      applyStimulus(1'b1, 32'h1000, 1'b1, "redir1000");
      applyStimulus(1'b0, 32'h0, 1'b1, "frozen2");

      applyReset();
      applyStimulus(1'b1, 32'hFF4, 1'b0, "redirFF4");
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b0, "topfill");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, "topdrain");
      applyStimulus(1'b1, 32'h10, 1'b1, "faultredir");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, "drained");

      applyReset();
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, "prereset");
      #2 reset_n = 1'b0;
      modelReset();
      #1 compareAll("asyncreset");
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, "restart");

      for (int round = 0; round < 4; round++) begin
         applyReset();
         for (int i = 0; i < 150; i++) begin
            logic rv;
            rv = ($urandom_range(0, 9) == 0);
            applyStimulus(rv, randTarget(), 1'($urandom_range(0, 3) != 0), "random");
         end
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
